// File: rtl/tt_um_uwasic_onboarding_henry_wu_if.sv
// tt_um_uwasic_onboarding_henry_wu_if: Tiny Tapeout pin bundle for the SPI-programmed PWM peripheral.
interface tt_um_uwasic_onboarding_henry_wu_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_uwasic_onboarding_henry_wu.sv
// tt_um_uwasic_onboarding_henry_wu: SPI mode-0 write-only register file driving 16 PWM/static outputs.
// Define SPI_SYNC3_EN for 3-flop input synchronizers instead of 2.
module tt_um_uwasic_onboarding_henry_wu (
    input logic clk,
    input logic rst_n,
    tt_um_uwasic_onboarding_henry_wu_if.slave bus
);
`ifdef SPI_SYNC3_EN
    localparam int SN = 3;
`else
    localparam int SN = 2;
`endif
    logic [SN-1:0] sclk_s, copi_s, ncs_s;
    logic sclk_d, ncs_d, wr_en, pwm, unused_ok;
    logic sclk_q, copi_q, ncs_q, sclk_rise, ncs_fall, ncs_rise;
    logic [15:0] shift, en_out, en_pwm, out;
    logic [4:0] cnt;
    logic [7:0] duty, pwm_cnt;
    logic [3:0] presc;
    assign sclk_q = sclk_s[SN-1];
    assign copi_q = copi_s[SN-1];
    assign ncs_q = ncs_s[SN-1];
    assign sclk_rise = sclk_q & ~sclk_d;
    assign ncs_fall = ~ncs_q & ncs_d;
    assign ncs_rise = ncs_q & ~ncs_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= '0;
            copi_s <= '0;
            ncs_s <= '1;
            sclk_d <= 1'b0;
            ncs_d <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[SN-2:0], bus.ui_in[0]};
            copi_s <= {copi_s[SN-2:0], bus.ui_in[1]};
            ncs_s <= {ncs_s[SN-2:0], bus.ui_in[2]};
            sclk_d <= sclk_q;
            ncs_d <= ncs_q;
        end
    end
    // bit count saturates at 17 so over-long frames stay distinguishable from 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            cnt <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= ncs_rise && cnt == 5'd16 && shift[15];
            if (ncs_fall) cnt <= '0;
            else if (sclk_rise && !ncs_q) begin
                shift <= {shift[14:0], copi_q};
                cnt <= (cnt == 5'd17) ? cnt : cnt + 5'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out <= '0;
            en_pwm <= '0;
            duty <= '0;
        end else if (wr_en) begin
            case (shift[14:8])
                7'h00: en_out[7:0] <= shift[7:0];
                7'h01: en_out[15:8] <= shift[7:0];
                7'h02: en_pwm[7:0] <= shift[7:0];
                7'h03: en_pwm[15:8] <= shift[7:0];
                7'h04: duty <= shift[7:0];
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pwm_cnt <= '0;
        end else if (presc == 4'd12) begin
            presc <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc <= presc + 4'd1;
        end
    end
    assign pwm = (duty == 8'hFF) | (pwm_cnt < duty);
    assign out = en_out & (~en_pwm | {16{pwm}});
    assign bus.uo_out = out[7:0];
    assign bus.uio_out = out[15:8];
    assign bus.uio_oe = 8'hFF;
    assign unused_ok = &{1'b0, bus.ena, bus.ui_in[7:3], bus.uio_in};
endmodule

// File: tb/tb_tt_um_uwasic_onboarding_henry_wu.sv
// tb_tt_um_uwasic_onboarding_henry_wu: directed SPI writes and PWM timing checks.
module tb_tt_um_uwasic_onboarding_henry_wu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    int total = 0, bad = 0;
    tt_um_uwasic_onboarding_henry_wu_if bus();
    assign bus.ena = 1'b1;
    assign bus.uio_in = 8'h00;
    assign bus.ui_in = {5'b0, ncs, copi, sclk};
    tt_um_uwasic_onboarding_henry_wu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [16:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = f[i];
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_send(input logic [16:0] f, input int n);
        ncs = 1'b0;
        clks(4);
        spi_bits(f, n);
        clks(4);
        ncs = 1'b1;
        clks(10);
    endtask

    task automatic wr(input logic [15:0] f);
        spi_send({1'b0, f}, 16);
    endtask

    initial begin
        int t, hi, lo;
        clks(3);
        check("rst_uo", bus.uo_out, 8'h00);
        check("rst_uio", bus.uio_out, 8'h00);
        check("rst_oe", bus.uio_oe, 8'hFF);
        rst_n = 1'b1;
        clks(3);
        check("post_rst_uo", bus.uo_out, 8'h00);
        wr(16'h80F0);
        check("wr0_uo", bus.uo_out, 8'hF0);
        check("wr0_uio", bus.uio_out, 8'h00);
        wr(16'h81CC);
        check("wr1_uio", bus.uio_out, 8'hCC);
        wr(16'hB0AA);
        check("badaddr_uo", bus.uo_out, 8'hF0);
        check("badaddr_uio", bus.uio_out, 8'hCC);
        wr(16'h0012);
        check("read_uo", bus.uo_out, 8'hF0);
        spi_send(17'h18055, 17);
        check("len17_uo", bus.uo_out, 8'hF0);
        spi_send({2'b0, 15'h00AB}, 15);
        check("len15_uo", bus.uo_out, 8'hF0);
        wr(16'h8001);
        wr(16'h8201);
        wr(16'h8480);
        t = 0;
        while (bus.uo_out[0] !== 1'b0 && t < 10000) begin @(negedge clk); t++; end
        while (bus.uo_out[0] !== 1'b1 && t < 10000) begin @(negedge clk); t++; end
        hi = 0;
        while (bus.uo_out[0] === 1'b1 && hi < 10000) begin @(negedge clk); hi++; end
        lo = 0;
        while (bus.uo_out[0] === 1'b0 && lo < 10000) begin @(negedge clk); lo++; end
        check("pwm50_high", hi, 1664);
        check("pwm50_period", hi + lo, 3328);
        check("pwm50_others", bus.uo_out & 8'hFE, 8'h00);
        check("pwm50_uio", bus.uio_out, 8'hCC);
        wr(16'h8400);
        hi = 0;
        for (int i = 0; i < 6700; i++) begin @(negedge clk); hi += int'(bus.uo_out[0]); end
        check("duty00_highs", hi, 0);
        wr(16'h84FF);
        lo = 0;
        for (int i = 0; i < 6700; i++) begin @(negedge clk); lo += int'(!bus.uo_out[0]); end
        check("dutyFF_lows", lo, 0);
        wr(16'h8003);
        check("static_and_pwm", bus.uo_out, 8'h03);
        wr(16'h8480);
        ncs = 1'b0;
        clks(4);
        spi_bits(17'h000F0, 8);
        #2 rst_n = 1'b0;
        #1;
        check("async_uo", bus.uo_out, 8'h00);
        check("async_uio", bus.uio_out, 8'h00);
        check("async_oe", bus.uio_oe, 8'hFF);
        clks(3);
        rst_n = 1'b1;
        clks(2);
        spi_bits(17'h000F0, 8);
        clks(4);
        ncs = 1'b1;
        clks(10);
        check("rel_uo", bus.uo_out, 8'h00);
        check("rel_uio", bus.uio_out, 8'h00);
        wr(16'h80F0);
        check("rel_wr_uo", bus.uo_out, 8'hF0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_um_uwasic_onboarding_henry_wu.md
TT_UM_UWASIC_ONBOARDING_HENRY_WU -- requirements
Module: tt_um_uwasic_onboarding_henry_wu

Interface
REQ-001 SHALL provide clk  input  1  system clock, 10 MHz nominal, all state on rising edge.
REQ-002 SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide ena  input  1  design-selected flag; ignored.
REQ-004 SHALL provide ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (SPI, mode 0); [7:3] unused.
REQ-005 SHALL provide uio_in  input  8  unused.
REQ-006 SHALL provide uo_out  output  8  channel outputs out[7:0].
REQ-007 SHALL provide uio_out  output  8  channel outputs out[15:8].
REQ-008 SHALL provide uio_oe  output  8  constant 8'hFF (all bidirectional pins driven).

Function
REQ-009 SHALL pass SCLK, COPI and nCS through 2-flop synchronizers into the clk domain before use; SCLK rising edge detected from synchronized samples.
REQ-010 SHALL, while synchronized nCS low, shift synchronized COPI into a 16-bit frame on each SCLK rising edge, MSB first; nCS falling edge clears bit count.
REQ-011 SHALL decode frame as bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-012 SHALL commit a write on synchronized nCS rising edge only when exactly 16 bits were received and bit15 = 1; frames with fewer or more bits, or bit15 = 0, are discarded with no state change.
REQ-013 SHALL implement write-only registers: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty[7:0]; addresses 0x05-0x7F ignored.
REQ-014 SHALL update a register one clk after the nCS-rise detection; no read-back path exists.
REQ-015 SHALL divide clk by 13 (prescaler 0..12) to advance an 8-bit PWM counter 0..255 with wrap (period 3328 clk, ~3.0 kHz at 10 MHz).
REQ-016 SHALL generate pwm = 1 when counter < duty; duty 0x00 -> constant 0; duty 0xFF -> constant 1 (override).
REQ-017 SHALL drive out[i] = 0 if en_out[i]=0; = 1 if en_out[i]=1 and en_pwm[i]=0; = pwm if both 1; all 16 channels share one pwm signal, phase-aligned.
REQ-018 SHALL let register writes take effect immediately on outputs (no period-boundary latching); counter not reset by writes.

Reset
REQ-019 SHALL, while rst_n low, clear all five registers, the PWM prescaler/counter, SPI shift/bit-count state, and load synchronizers with idle values (SCLK=0, COPI=0, nCS=1).
REQ-020 SHALL hold uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF during and after reset until written.
REQ-021 SHALL abort any in-progress SPI frame on reset; no partial write commits.

Configuration
REQ-022 SHALL, with macro SPI_SYNC3_EN defined, use 3-flop synchronizers on SCLK/COPI/nCS (one extra clk of input latency); without it, 2-flop synchronizers per REQ-009; register map and PWM behaviour identical either way.

Verification
REQ-023 Reset, then write 0x00<-0xF0 (frame 0x80F0) -> uo_out = 0xF0, uio_out = 0x00.
REQ-024 Write 0x01<-0xCC -> uio_out = 0xCC; write 0x30<-0xAA (invalid addr) -> no output change.
REQ-025 Read frame 0x0012 (bit15=0) or 15-bit frame -> no register change.
REQ-026 en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328 clk ±1, high 1664 clk (50%).
REQ-027 duty=0x00 -> uo_out[0] constant 0; duty=0xFF -> constant 1 over ≥2 periods.
REQ-028 Assert rst_n low mid-frame and mid-PWM -> all outputs 0 immediately (async), registers 0 after release.
